// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared 64-bit simulation memory data port.
// Grants one transaction per IDLE/RESP pair and returns a one-cycle response pulse per transaction.
module mem_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_be,
    input  logic [63:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_be,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_be_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,

    output logic        dbg_state_o
);

    // Handshake: mN_req acts as valid and mN_gnt as ready; a transfer happens on a cycle
    // where both are high, and the master holds req and payload stable until that cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_prio;
    logic        r_winner;
    logic        r_err;
    logic [63:0] r_rdata;

    logic        w_idle;
    logic        w_resp;
    logic        w_win;
    logic        w_accept;
    logic        w_in_range;
    logic        w_we;
    logic [7:0]  w_be;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;

    always_comb begin
        // Reset blanks every output in the same cycle, so a pending response is dropped.
        w_idle = (r_state == ST_IDLE) && !rst;
        w_resp = (r_state == ST_RESP) && !rst;
        if (m0_req && m1_req) begin
            w_win = r_prio;
        end else begin
            w_win = m1_req;
        end
        w_accept   = w_idle && (m0_req || m1_req);
        w_we       = w_win ? m1_we    : m0_we;
        w_be       = w_win ? m1_be    : m0_be;
        w_addr     = w_win ? m1_addr  : m0_addr;
        w_wdata    = w_win ? m1_wdata : m0_wdata;
        w_in_range = (w_addr[63:ADDR_W] == '0);
    end

    always_comb begin
        m0_gnt      = w_accept && !w_win;
        m1_gnt      = w_accept &&  w_win;
        mem_req_o   = w_accept && w_in_range;
        mem_we_o    = w_accept && w_we;
        mem_be_o    = w_accept ? w_be    : 8'h00;
        mem_addr_o  = w_accept ? w_addr  : 64'h0;
        mem_wdata_o = w_accept ? w_wdata : 64'h0;
    end

    always_comb begin
        m0_rvalid = w_resp && !r_winner;
        m1_rvalid = w_resp &&  r_winner;
        m0_rdata  = m0_rvalid ? r_rdata : 64'h0;
        m1_rdata  = m1_rvalid ? r_rdata : 64'h0;
        m0_err    = m0_rvalid && r_err;
        m1_err    = m1_rvalid && r_err;
    end

    assign dbg_state_o = (r_state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_prio   <= 1'b0;
            r_winner <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 64'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_RESP;
                        r_winner <= w_win;
                        r_err    <= !w_in_range;
                        r_rdata  <= (w_in_range && !w_we) ? mem_rdata_i : 64'h0;
                        // The loser gets priority next time, even if it was not asking.
                        r_prio   <= !w_win;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory environment, directed scenarios and random
// traffic checked cycle by cycle against an arbitration/response reference model.
module tb_mem_port_arbiter;

    localparam int AW        = 12;
    localparam int MEM_BYTES = 1 << AW;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_be, m1_be;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [63:0] m0_rdata, m1_rdata;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_be_o;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory environment ----------------
    bit [7:0]    env_mem [MEM_BYTES];
    logic        pl_we = 1'b0;
    logic [63:0] pl_addr = '0;
    logic [63:0] pl_data = '0;

    always_comb begin
        mem_rdata_i = '0;
        for (int i = 0; i < 8; i++)
            mem_rdata_i[8*i +: 8] = env_mem[mem_addr_o[AW-1:0] + AW'(i)];
    end

    always @(posedge clk) begin
        if (pl_we) begin
            for (int i = 0; i < 8; i++) env_mem[pl_addr[AW-1:0] + AW'(i)] <= pl_data[8*i +: 8];
        end else if (mem_req_o && mem_we_o) begin
            for (int i = 0; i < 8; i++)
                if (mem_be_o[i]) env_mem[mem_addr_o[AW-1:0] + AW'(i)] <= mem_wdata_o[8*i +: 8];
        end
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Expected response entries: {master id, err, rdata}, pushed on grant, popped next cycle.
    bit [7:0]    shadow [MEM_BYTES];
    logic [65:0] exp_q[$];
    int          m_prio = 0;
    int          gnt_cnt0 = 0, gnt_cnt1 = 0;

    function automatic logic [63:0] sh_read(input logic [63:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = shadow[a[AW-1:0] + AW'(i)];
        return r;
    endfunction

    always @(negedge clk) begin
        logic [65:0] e;
        int          w;
        logic        wwe, in_rng;
        logic [7:0]  wbe;
        logic [63:0] wa, wd, rd;
        if (rst) begin
            check_eq("rst_gnt0", m0_gnt, 0);
            check_eq("rst_gnt1", m1_gnt, 0);
            check_eq("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
            check_eq("rst_mem_req", mem_req_o, 0);
            check_eq("rst_mem_addr", mem_addr_o, 0);
            exp_q.delete();
            m_prio = 0;
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("resp_state", dbg_state_o, 1);
            check_eq("resp_rvalid0", m0_rvalid, e[65] == 1'b0);
            check_eq("resp_rvalid1", m1_rvalid, e[65] == 1'b1);
            check_eq("resp_rdata", e[65] ? m1_rdata : m0_rdata, e[63:0]);
            check_eq("resp_err", e[65] ? m1_err : m0_err, e[64]);
            check_eq("resp_other_rdata", e[65] ? m0_rdata : m1_rdata, 0);
            check_eq("resp_no_gnt", {m1_gnt, m0_gnt}, 0);
            check_eq("resp_mem_quiet", {mem_req_o, mem_we_o, mem_be_o}, 0);
        end else begin
            check_eq("idle_state", dbg_state_o, 0);
            check_eq("idle_rvalid", {m1_rvalid, m0_rvalid, m1_err, m0_err}, 0);
            check_eq("idle_rdata", m0_rdata | m1_rdata, 0);
            if (m0_req || m1_req) begin
                w      = (m0_req && m1_req) ? m_prio : (m1_req ? 1 : 0);
                wwe    = w ? m1_we    : m0_we;
                wbe    = w ? m1_be    : m0_be;
                wa     = w ? m1_addr  : m0_addr;
                wd     = w ? m1_wdata : m0_wdata;
                in_rng = (wa >> AW) == 0;
                check_eq("gnt0", m0_gnt, w == 0);
                check_eq("gnt1", m1_gnt, w == 1);
                check_eq("mem_req", mem_req_o, in_rng);
                check_eq("mem_we", mem_we_o, wwe);
                check_eq("mem_be", mem_be_o, wbe);
                check_eq("mem_addr", mem_addr_o, wa);
                check_eq("mem_wdata", mem_wdata_o, wd);
                rd = (in_rng && !wwe) ? sh_read(wa) : 64'h0;
                if (in_rng && wwe)
                    for (int i = 0; i < 8; i++)
                        if (wbe[i]) shadow[wa[AW-1:0] + AW'(i)] = wd[8*i +: 8];
                exp_q.push_back({w[0], !in_rng, rd});
                m_prio = 1 - w;
            end else begin
                check_eq("no_req_gnt", {m1_gnt, m0_gnt}, 0);
                check_eq("no_req_mem", {mem_req_o, mem_we_o, mem_be_o}, 0);
                check_eq("no_req_addr", mem_addr_o | mem_wdata_o, 0);
            end
        end
        if (pl_we)
            for (int i = 0; i < 8; i++) shadow[pl_addr[AW-1:0] + AW'(i)] = pl_data[8*i +: 8];
        if (m0_gnt) gnt_cnt0++;
        if (m1_gnt) gnt_cnt1++;
    end

    // ---------------- driver tasks ----------------
    int seen0 = 0, seen1 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (gnt_cnt0 != seen0) begin seen0 = gnt_cnt0; m0_req = 1'b0; end
        if (gnt_cnt1 != seen1) begin seen1 = gnt_cnt1; m1_req = 1'b0; end
    endtask

    task automatic set_req(input int m, input logic we, input logic [7:0] be,
                           input logic [63:0] addr, input logic [63:0] wd);
        if (m == 0) begin
            m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end
    endtask

    task automatic rand_req(input int m);
        logic [63:0] a;
        a = 64'($urandom_range(0, MEM_BYTES - 1));
        if ($urandom_range(0, 7) == 0) a[63 - $urandom_range(0, 63 - AW)] = 1'b1;
        set_req(m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), a, {$urandom, $urandom});
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        tick();
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_gnt : m1_gnt;
    endfunction

    function automatic logic rvalid_of(input int m);
        return (m == 0) ? m0_rvalid : m1_rvalid;
    endfunction

    task automatic do_txn(input int m, input logic we, input logic [7:0] be,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er);
        int k;
        tick();
        set_req(m, we, be, addr, wd);
        @(negedge clk);
        k = 0;
        while (!gnt_of(m) && k < 16) begin
            tick();
            @(negedge clk);
            k++;
        end
        check_eq("txn_grant_wait", 64'(k < 16), 1);
        tick();
        @(negedge clk);
        check_eq("txn_rvalid", rvalid_of(m), 1);
        rd = (m == 0) ? m0_rdata : m1_rdata;
        er = (m == 0) ? m0_err : m1_err;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rd, envw;
        logic        er;
        int          issued, done, p;

        rst = 1'b1;
        {m0_req, m0_we, m0_be, m0_addr, m0_wdata} = '0;
        {m1_req, m1_we, m1_be, m1_addr, m1_wdata} = '0;
        preload(64'h0, 64'h00A00113_00500093);
        tick();
        @(negedge clk);
        check_eq("reset_outputs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_req_o}, 0);
        tick();
        rst = 1'b0;

        // Single read
        do_txn(0, 1'b0, 8'hFF, 64'h0, 64'h0, rd, er);
        check_eq("single_read_rdata", rd, 64'h00A0011300500093);
        check_eq("single_read_err", er, 0);
        check_eq("single_read_m1_quiet", {m1_rvalid, m1_err, m1_rdata}, 0);

        // Write then read-back
        do_txn(1, 1'b1, 8'h0F, 64'h100, 64'hDEADBEEF_CAFEF00D, rd, er);
        check_eq("write_rdata", rd, 0);
        check_eq("write_err", er, 0);
        do_txn(1, 1'b0, 8'hFF, 64'h100, 64'h0, rd, er);
        check_eq("readback_rdata", rd, 64'h00000000_CAFEF00D);

        // Out of range write must not touch memory
        do_txn(0, 1'b1, 8'hFF, 64'h1000, 64'h1111_2222_3333_4444, rd, er);
        check_eq("oor_err", er, 1);
        check_eq("oor_rdata", rd, 0);
        for (int i = 0; i < 8; i++) envw[8*i +: 8] = env_mem[i];
        check_eq("oor_mem_unchanged", envw, 64'h00A0011300500093);

        // Contention from reset: strict alternation m0, m1
        tick(); rst = 1'b1;
        drain(2);
        rst = 1'b0;
        set_req(0, 1'b0, 8'hFF, 64'h0, 64'h0);
        set_req(1, 1'b0, 8'hFF, 64'h100, 64'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("rr_gnt0", m0_gnt, (c % 4) == 0);
            check_eq("rr_gnt1", m1_gnt, (c % 4) == 2);
            check_eq("rr_rvalid0", m0_rvalid, (c % 4) == 1);
            check_eq("rr_rvalid1", m1_rvalid, (c % 4) == 3);
            tick();
            if (!m0_req) set_req(0, 1'b0, 8'hFF, 64'h0, 64'h0);
            if (!m1_req) set_req(1, 1'b0, 8'hFF, 64'h100, 64'h0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        drain(2);

        // Reset in the RESP cycle drops the response and restores prio
        set_req(1, 1'b0, 8'hFF, 64'h0, 64'h0);
        @(negedge clk);
        check_eq("mid_rst_gnt1", m1_gnt, 1);
        tick(); rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_no_rvalid", m1_rvalid, 0);
        tick(); rst = 1'b0;
        set_req(0, 1'b0, 8'hFF, 64'h8, 64'h0);
        set_req(1, 1'b0, 8'hFF, 64'h10, 64'h0);
        @(negedge clk);
        check_eq("post_rst_state", dbg_state_o, 0);
        check_eq("post_rst_gnt0", m0_gnt, 1);
        check_eq("post_rst_gnt1", m1_gnt, 0);
        drain(6);

        // Back-to-back reads from one master
        set_req(0, 1'b0, 8'hFF, 64'h0, 64'h0);
        issued = 1; done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("b2b_gnt0", m0_gnt, (c % 2) == 0);
            check_eq("b2b_rvalid0", m0_rvalid, (c % 2) == 1);
            if (m0_rvalid) done++;
            tick();
            if (!m0_req && issued < 4) begin
                set_req(0, 1'b0, 8'hFF, 64'(8 * issued), 64'h0);
                issued++;
            end
        end
        check_eq("b2b_done", done, 4);

        // Random traffic with occasional resets
        for (int c = 0; c < 900; c++) begin
            p = (c < 300) ? 25 : ((c < 600) ? 95 : 60);
            tick();
            rst = ($urandom_range(0, 149) == 0);
            if (!m0_req && $urandom_range(0, 99) < p) rand_req(0);
            if (!m1_req && $urandom_range(0, 99) < p) rand_req(1);
        end
        rst = 1'b0;
        drain(8);
        m0_req = 1'b0; m1_req = 1'b0;
        drain(3);
        @(negedge clk);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter for the shared 64-bit data port of the simulation memory. Grants one transaction at a time to either the load/store unit (master 0) or the program loader/debug master (master 1) using round-robin priority. It drives the memory's request/write-enable/byte-enable/address/write-data inputs and registers the combinational read data. Every transaction gets a one-cycle response pulse, with an error flag for out-of-range addresses.

## Interface
- ADDR_W, 12: implemented address bits; the memory holds 2^ADDR_W bytes.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  master N (N=0,1) request; held high until mN_gnt.
- mN_we  in  1  master N write enable (1 = write, 0 = read).
- mN_be  in  8  master N byte enables; write lanes only.
- mN_addr  in  64  master N byte address.
- mN_wdata  in  64  master N write data.
- mN_gnt  out  1  combinational accept of master N's request this cycle.
- mN_rvalid  out  1  one-cycle response pulse for master N (reads and writes).
- mN_rdata  out  64  read data, valid with mN_rvalid.
- mN_err  out  1  out-of-range flag, valid with mN_rvalid.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  8  memory byte enables.
- mem_addr_o  out  64  memory byte address.
- mem_wdata_o  out  64  memory write data.
- mem_rdata_i  in  64  memory read data, combinational from mem_addr_o.

## Operation
- FSM states IDLE and RESP. Reset state is IDLE.
- **IDLE, no request:** all mem_* outputs are 0 and no grant is issued.
- **IDLE, one request:** that master wins.
- **IDLE, both requesting:** the master named by the priority pointer `prio` wins. `prio` resets to 0.
- **Winner accepted (IDLE):**
  - mW_gnt = 1 combinationally.
  - mem_we_o/be_o/addr_o/wdata_o mirror the winner's inputs.
  - mem_req_o = 1 only if the address is in range.
  - Next state is RESP.
  - Latched: winner id, err flag, and, for in-range reads, mem_rdata_i.
  - `prio` is set to the loser's id (1 − W), whether or not the loser was requesting.
- **In range:** mW_addr[63:ADDR_W] == 0.
- **Out of range:** mem_req_o = 0, so no memory write occurs. Latched rdata = 0 and err = 1.
- **Write:** memory commits on the grant edge. Latched rdata = 0.
- **RESP:**
  - Latched master gets rvalid = 1 with its latched rdata and err.
  - No grants are issued and mem_* outputs are 0.
  - Next state is IDLE unconditionally.
- **Idle output values:** rdata/err outputs of a master not currently in RESP are 0. mem_* outputs are 0 whenever no grant is active.
- **Masters:** must hold req and payload stable until gnt. They may reassert req in the same cycle as rvalid; that request is granted in the following IDLE cycle.
- **Reset, any state:** next state IDLE, `prio` = 0, latches cleared. A pending RESP is dropped and rvalid is not produced.

## Timing
- Grant: 0-cycle latency from req in IDLE (combinational).
- Response: rvalid exactly 1 cycle after the grant cycle, high for 1 cycle.
- Throughput: one transaction per 2 cycles, alternating IDLE and RESP.
- Worst-case wait: a continuously requesting master waits at most 2 cycles (one foreign transaction) before grant.
- Reset values (all outputs): 0.
- Read data sampling: mem_rdata_i is sampled at the grant-cycle rising edge. Under simulation memory semantics a read is never affected by a write in the same cycle.

## Test plan
- **Single read:** preload mem[0..7] = 0x00A00113_00500093; m0 reads addr 0 → m0_gnt in cycle 0; m0_rvalid in cycle 1 with m0_rdata = 0x00A0011300500093, m0_err = 0; m1 outputs stay 0.
- **Write then read-back:** m1 writes addr 0x100, be = 0x0F, wdata = 0xDEADBEEF_CAFEF00D; m1 then reads 0x100 → rvalid for the write, then read rdata = 0x00000000_CAFEF00D.
- **Contention / round-robin:** m0 and m1 request continuously from reset → grants alternate m0, m1, m0, m1 on cycles 0, 2, 4, 6; each rvalid one cycle after its grant; no two grants in consecutive cycles.
- **Out of range:** m0 writes addr 0x1000 (ADDR_W = 12) → mem_req_o stays 0, memory contents unchanged, m0_rvalid with m0_err = 1, m0_rdata = 0.
- **Reset mid-operation:** grant m1 read, assert rst in the RESP cycle → m1_rvalid stays 0, state IDLE; after release, simultaneous requests grant m0 first (`prio` = 0).
- **Back-to-back same master:** m0 reasserts req in its rvalid cycle → grant in the next cycle; total of 4 reads completes in 8 cycles.
